// File: rtl/wb_arb_pkg.sv
// Shared interconnect definitions for the two-initiator Wishbone arbiter: bus widths,
// arbiter state encodings and the read value returned on a bus-error abort.
package wb_arb_pkg;

  localparam int unsigned WbAw    = 30;
  localparam int unsigned WbDw    = 32;
  localparam int unsigned WbSw    = WbDw / 8;
  localparam int unsigned WdtCntW = 8;

  localparam logic [WbDw-1:0] WbErrData = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbGnt0 = 2'd1,
    ArbGnt1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wb_arb_if.sv
// Wishbone classic bus bundle. The master modport is the initiator side of a link and
// the slave modport is the target side of the same link.
interface wb_arb_if
  import wb_arb_pkg::*;
#(
  parameter int unsigned AW = WbAw,
  parameter int unsigned DW = WbDw,
  parameter int unsigned SW = WbSw
) ();

  logic          cyc;
  logic          stb;
  logic          we;
  logic [SW-1:0] sel;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic          ack;
  logic [DW-1:0] dat_r;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  ack, dat_r
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output ack, dat_r
  );

endinterface

// File: rtl/wb_arb_wdt.sv
// Ack watchdog for the granted initiator: counts stalled strobe cycles and raises a
// one-cycle abort when the count reaches Timeout. Only built with WB_ARB_TIMEOUT_EN.
module wb_arb_wdt
  import wb_arb_pkg::*;
#(
  parameter int unsigned Timeout = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic ack_i,
  output logic abort_o
);

  localparam logic [WdtCntW-1:0] Limit = WdtCntW'(Timeout);

  logic [WdtCntW-1:0] cnt_q, cnt_d;

  assign abort_o = active_i && (cnt_q == Limit);

  // Idle, acked and aborted cycles all restart the count.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!active_i || ack_i || abort_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_arb.sv
// Round-robin two-initiator Wishbone arbiter with the grant locked for a whole cyc tenure.
// Define WB_ARB_TIMEOUT_EN to add the ack watchdog that aborts stalled strobes.
module wb_arb
  import wb_arb_pkg::*;
#(
  parameter int unsigned AW      = WbAw,
  parameter int unsigned DW      = WbDw,
  parameter int unsigned SW      = WbSw,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic     clk_i,
  input  logic     rst_i,
  wb_arb_if.slave  m0,
  wb_arb_if.slave  m1,
  wb_arb_if.master s
);

  arb_state_e state_q;
  logic       last_grant_q;

  logic          gnt0, gnt1;
  logic          bus_cyc, bus_stb_raw, bus_stb, bus_we;
  logic [SW-1:0] bus_sel;
  logic [AW-1:0] bus_adr;
  logic [DW-1:0] bus_dat_w;
  logic [DW-1:0] rdat;
  logic          ack_fwd;
  logic          abort;

  // Arbitration only happens from idle, so a release always costs one dead cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ArbIdle;
      last_grant_q <= 1'b1;
    end else begin
      unique case (state_q)
        ArbIdle: begin
          if (m0.cyc && (!m1.cyc || last_grant_q)) begin
            state_q      <= ArbGnt0;
            last_grant_q <= 1'b0;
          end else if (m1.cyc) begin
            state_q      <= ArbGnt1;
            last_grant_q <= 1'b1;
          end
        end
        ArbGnt0: if (!m0.cyc) state_q <= ArbIdle;
        ArbGnt1: if (!m1.cyc) state_q <= ArbIdle;
        default: state_q <= ArbIdle;
      endcase
    end
  end

  assign gnt0 = (state_q == ArbGnt0);
  assign gnt1 = (state_q == ArbGnt1);

  always_comb begin
    bus_cyc     = 1'b0;
    bus_stb_raw = 1'b0;
    bus_we      = 1'b0;
    bus_sel     = '0;
    bus_adr     = '0;
    bus_dat_w   = '0;
    if (gnt0) begin
      bus_cyc     = m0.cyc;
      bus_stb_raw = m0.stb;
      bus_we      = m0.we;
      bus_sel     = m0.sel;
      bus_adr     = m0.adr;
      bus_dat_w   = m0.dat_w;
    end else if (gnt1) begin
      bus_cyc     = m1.cyc;
      bus_stb_raw = m1.stb;
      bus_we      = m1.we;
      bus_sel     = m1.sel;
      bus_adr     = m1.adr;
      bus_dat_w   = m1.dat_w;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_wdt #(
    .Timeout (TIMEOUT)
  ) u_wdt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .active_i (bus_stb_raw),
    .ack_i    (s.ack),
    .abort_o  (abort)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign abort          = 1'b0;
`endif

  // An abort withdraws the strobe and answers the initiator with an error read value.
  assign bus_stb = bus_stb_raw && !abort;
  assign ack_fwd = (s.ack && bus_stb) || abort;
  assign rdat    = abort ? WbErrData : s.dat_r;

  assign s.cyc   = bus_cyc;
  assign s.stb   = bus_stb;
  assign s.we    = bus_we;
  assign s.sel   = bus_sel;
  assign s.adr   = bus_adr;
  assign s.dat_w = bus_dat_w;

  assign m0.ack   = gnt0 && ack_fwd;
  assign m0.dat_r = gnt0 ? rdat : '0;
  assign m1.ack   = gnt1 && ack_fwd;
  assign m1.dat_r = gnt1 ? rdat : '0;

endmodule

// File: tb/tb_wb_arb.sv
// Directed bench for wb_arb: scoreboarded accesses, round-robin order, burst locking,
// spurious acks, mid-transaction reset and the optional ack timeout.
module tb_wb_arb;
  import wb_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arb_if m0_if ();
  wb_arb_if m1_if ();
  wb_arb_if s_if ();

  wb_arb #(
    .TIMEOUT (8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if)
  );

  typedef struct {
    int          who;
    logic [31:0] dat;
  } sb_t;

  sb_t sb[$];
  int  tests = 0;
  int  fails = 0;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int who, input logic on, input logic we, input logic [29:0] adr,
                     input logic [31:0] wd);
    if (who == 0) begin
      m0_if.cyc = on; m0_if.stb = on; m0_if.we = we; m0_if.sel = 4'hF;
      m0_if.adr = adr; m0_if.dat_w = wd;
    end else begin
      m1_if.cyc = on; m1_if.stb = on; m1_if.we = we; m1_if.sel = 4'hF;
      m1_if.adr = adr; m1_if.dat_w = wd;
    end
  endtask

  // Plays the target: acks the lat-th strobed cycle with the scoreboard head's data.
  task automatic serve(input string tag, input int lat);
    sb_t e;
    bit  done = 0;
    int  n = 0;
    e = sb.pop_front();
    for (int i = 0; i < 32 && !done; i++) begin
      #1;
      if (s_if.cyc && s_if.stb) begin
        if (n == lat) begin
          s_if.ack   = 1'b1;
          s_if.dat_r = e.dat;
          #1;
          chk({tag, "_ack"}, (e.who == 0) ? m0_if.ack : m1_if.ack, 1);
          chk({tag, "_dat"}, (e.who == 0) ? m0_if.dat_r : m1_if.dat_r, e.dat);
          chk({tag, "_other"}, (e.who == 0) ? m1_if.ack : m0_if.ack, 0);
          done = 1;
        end
        n++;
      end
      nxt();
      s_if.ack   = 1'b0;
      s_if.dat_r = '0;
    end
    chk({tag, "_served"}, done, 1);
  endtask

  initial begin
    int acks;
    req(0, 0, 0, '0, '0);
    req(1, 0, 0, '0, '0);
    s_if.ack   = 1'b0;
    s_if.dat_r = '0;
    nxt(); nxt();
    rst = 1'b0;
    #1;
    chk("rst_cyc", s_if.cyc, 0);
    chk("rst_ack0", m0_if.ack, 0);
    chk("rst_ack1", m1_if.ack, 0);

    // Single m0 read, target acks after two wait cycles.
    req(0, 1, 0, 30'h0400_0000, '0);
    sb.push_back('{0, 32'hDEAD_BEEF});
    #1;
    chk("t1_no_comb", s_if.cyc, 0);
    nxt(); #1;
    chk("t1_cyc", s_if.cyc, 1);
    chk("t1_adr", s_if.adr, 30'h0400_0000);
    serve("t1", 2);
    req(0, 0, 0, '0, '0);
    #1;
    chk("t1_ack_drop", m0_if.ack, 0);
    nxt(); #1;
    chk("t1_idle", s_if.cyc, 0);

    // Simultaneous requests from reset: m0, m1, m0, m1 with one dead cycle between.
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      req(0, 1, 0, 30'(30'h100 + r), '0);
      req(1, 1, 0, 30'(30'h200 + r), '0);
      sb.push_back('{0, 32'hA000_0000 + r});
      sb.push_back('{1, 32'hB000_0000 + r});
      nxt(); #1;
      chk("t2_g0_adr", s_if.adr, 30'(30'h100 + r));
      serve("t2_m0", 0);
      req(0, 0, 0, '0, '0);
      nxt(); #1;
      chk("t2_dead", s_if.cyc, 0);
      nxt(); #1;
      chk("t2_g1_cyc", s_if.cyc, 1);
      chk("t2_g1_adr", s_if.adr, 30'(30'h200 + r));
      serve("t2_m1", 1);
      req(1, 0, 0, '0, '0);
      nxt();
    end

    // m1 four-beat burst, m0 requests at beat 2 and must wait for the release.
    req(1, 1, 1, 30'h0300_0000, 32'h1111_2222);
    for (int k = 0; k < 4; k++) sb.push_back('{1, 32'hC000_0000 + k});
    nxt(); #1;
    chk("t3_g1", s_if.cyc, 1);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) req(0, 1, 0, 30'h0500_0000, '0);
      #1;
      chk("t3_owner", s_if.adr, 30'h0300_0000);
      serve("t3_beat", 0);
    end
    req(1, 0, 1, '0, '0);
    sb.push_back('{0, 32'h5555_AAAA});
    nxt(); #1;
    chk("t3_dead", s_if.cyc, 0);
    nxt(); #1;
    chk("t3_g0_adr", s_if.adr, 30'h0500_0000);
    serve("t3_m0", 0);
    req(0, 0, 0, '0, '0);
    nxt();

    // Spurious acks in idle and while granted without a strobe.
    s_if.ack = 1'b1;
    #1;
    chk("t4_idle_ack0", m0_if.ack, 0);
    chk("t4_idle_ack1", m1_if.ack, 0);
    s_if.ack  = 1'b0;
    m0_if.cyc = 1'b1;
    nxt();
    s_if.ack = 1'b1;
    #1;
    chk("t4_gnt_cyc", s_if.cyc, 1);
    chk("t4_gnt_stb", s_if.stb, 0);
    chk("t4_gnt_ack0", m0_if.ack, 0);
    s_if.ack  = 1'b0;
    m0_if.cyc = 1'b0;
    nxt();

    // Reset during the wait state of an m0 write; late ack is dropped, m0 wins next tie.
    req(0, 1, 1, 30'h0600_0000, 32'hCAFE_F00D);
    nxt(); #1;
    chk("t5_we", s_if.we, 1);
    chk("t5_wdat", s_if.dat_w, 32'hCAFE_F00D);
    rst = 1'b1;
    nxt();
    rst      = 1'b0;
    s_if.ack = 1'b1;
    #1;
    chk("t5_cyc", s_if.cyc, 0);
    chk("t5_late_ack", m0_if.ack, 0);
    req(0, 0, 0, '0, '0);
    s_if.ack = 1'b0;
    nxt();
    req(0, 1, 0, 30'h0700_0000, '0);
    req(1, 1, 0, 30'h0800_0000, '0);
    sb.push_back('{0, 32'h7777_0000});
    nxt(); #1;
    chk("t5_last_grant", s_if.adr, 30'h0700_0000);
    serve("t5_m0", 0);
    req(0, 0, 0, '0, '0);
    nxt();
    sb.push_back('{1, 32'h8888_0000});
    nxt();
    serve("t5_m1", 0);
    req(1, 0, 0, '0, '0);
    nxt();

    // Target never acks.
    req(0, 1, 0, 30'h0900_0000, '0);
    nxt();
    acks = 0;
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      #1;
      acks += int'(m0_if.ack);
      nxt();
    end
    chk("t6_early_ack", acks, 0);
    #1;
    chk("t6_abort_ack", m0_if.ack, 1);
    chk("t6_abort_dat", m0_if.dat_r, WbErrData);
    chk("t6_abort_stb", s_if.stb, 0);
    nxt(); #1;
    chk("t6_rearm_stb", s_if.stb, 1);
    chk("t6_rearm_ack", m0_if.ack, 0);
`else
    for (int k = 0; k < 20; k++) begin
      #1;
      acks += int'(m0_if.ack);
      nxt();
    end
    #1;
    chk("t6_no_ack", acks, 0);
    chk("t6_stb_held", s_if.stb, 1);
`endif
    req(0, 0, 0, '0, '0);
    nxt(); nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
